// File: rtl/data_mem_unit.sv
// data_mem_unit
// Single-port data memory with byte/halfword/word loads and stores, alignment
// and range checking, and a fixed, parameterised read latency. One request is
// handled at a time: IDLE accepts, WAIT pads load latency, RESP pulses the
// response.
//
// Parameters
//   DEPTH        number of 32-bit words (power of 2, 4..4096)
//   RD_LAT       load latency in cycles (1..4)
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous active-low reset
//   req_valid    request present
//   req_ready    request can be accepted (IDLE only, low in reset)
//   req_we       1 = store, 0 = load
//   req_size     00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned load zero-extends when 1, sign-extends when 0
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   rsp_valid    one-cycle response pulse
//   rsp_rdata    load data extended to 32 bits, 0 otherwise
//   rsp_err      request faulted, qualified by rsp_valid
//   err_count    saturating count of faulted requests
module data_mem_unit #(
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state;
    state_t         state_next;
    logic [1:0]     wait_cnt;
    logic           accept;
    logic           fault;
    logic [AW-1:0]  word_idx;
    logic [3:0]     byte_en;
    logic [31:0]    wdata_lanes;

    logic           lat_we;
    logic           lat_fault;
    logic [1:0]     lat_size;
    logic           lat_unsigned;
    logic [1:0]     lat_lane;
    logic [31:0]    rd_word;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    load_data;

    // Memory starts zeroed and is deliberately outside the reset domain.
    logic [31:0]    mem [DEPTH] = '{default: 32'h0};

    // Gating with RST keeps ready low while reset is held, even though the
    // state register already sits in IDLE.
    assign req_ready = RST && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[AW+1:2];

    always_comb begin
        fault = 1'b0;
        case (req_size)
            2'b00:   fault = 1'b0;
            2'b01:   fault = req_addr[0];
            2'b10:   fault = |req_addr[1:0];
            default: fault = 1'b1;
        endcase
        if (req_addr[31:2] >= 30'(DEPTH))
            fault = 1'b1;
    end

    // Replicating the store data across lanes lets one byte-enable mask
    // pick the addressed lanes for every size.
    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = 32'h0;
        case (req_size)
            2'b00: begin
                byte_en     = 4'b0001 << req_addr[1:0];
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en     = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                byte_en     = 4'b1111;
                wdata_lanes = req_wdata;
            end
            default: begin
                byte_en     = 4'b0000;
                wdata_lanes = 32'h0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Stores and faults have nothing to wait for, so they go straight to RESP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_we || fault || (RD_LAT == 1))
                        state_next = RESP;
                    else
                        state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST)
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counts cycles spent in WAIT; cleared whenever outside WAIT.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            wait_cnt <= 2'd0;
        else if (state == WAIT)
            wait_cnt <= wait_cnt + 2'd1;
        else
            wait_cnt <= 2'd0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lat_we       <= 1'b0;
            lat_fault    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_lane     <= 2'b00;
        end else if (accept) begin
            lat_we       <= req_we;
            lat_fault    <= fault;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_lane     <= req_addr[1:0];
        end
    end

    // The word is read on the accept edge; every earlier store has already
    // landed by then because only one request is ever in flight.
    always_ff @(posedge CLK) begin
        if (accept) begin
            if (req_we && !fault) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i])
                        mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
            rd_word <= mem[word_idx];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            err_count <= 8'd0;
        else if (accept && fault && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end

    assign byte_sel = rd_word[{lat_lane, 3'b000} +: 8];
    assign half_sel = lat_lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (lat_size)
            2'b00:   load_data = lat_unsigned ? {24'h0, byte_sel}
                                              : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = lat_unsigned ? {16'h0, half_sel}
                                              : {{16{half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid && lat_fault;
    assign rsp_rdata = (rsp_valid && !lat_fault && !lat_we) ? load_data : 32'h0;

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH, 64, number of 32-bit words; power of 2, 4..4096.
- RD_LAT, 1, read latency in cycles; 1..4.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  single clock; all state changes on its rising edge.
- RST  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data, extended to 32 bits.
- rsp_err  out  1  request faulted; qualifies rsp_valid.
- err_count  out  8  saturating count of faulted requests.

Function
REQ-003 A request SHALL be accepted on a rising CLK edge where req_valid=1 and req_ready=1; other edges SHALL ignore the req_* inputs.
REQ-004 The FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-005 Transitions SHALL be: IDLE->RESP on accepting a store, a faulted request, or a load with RD_LAT=1; IDLE->WAIT on accepting a load with RD_LAT>1; WAIT->RESP after RD_LAT-1 cycles in WAIT; RESP->IDLE unconditionally.
REQ-006 rsp_valid SHALL be 1 exactly in RESP, giving latency RD_LAT for loads and 1 for stores and faults, and throughput of one request per latency+1 cycles.
REQ-007 Word index SHALL be req_addr[log2(DEPTH)+1:2]; byte lane SHALL be req_addr[1:0], little-endian (lane 0 = bits 7:0).
REQ-008 The request SHALL fault when req_size=11, when a halfword has addr[0]=1, when a word has addr[1:0]!=00, or when req_addr[31:2] >= DEPTH.
REQ-009 On a fault there SHALL be no memory write; the response SHALL have rsp_err=1 and rsp_rdata=0.
REQ-010 err_count SHALL increment at the accept edge of each faulted request and hold at 255.
REQ-011 A store SHALL write on its accept edge, to the addressed lanes only:
- byte: wdata[7:0] to lane addr[1:0].
- halfword: wdata[15:0] to lanes addr[1]*2+1 : addr[1]*2.
- word: all four lanes.
- The store response SHALL have rsp_rdata=0 and rsp_err=0.
REQ-012 A load SHALL latch address, size and unsigned flag at accept.
- It SHALL read the word so the returned value reflects every store accepted before it.
- It SHALL extract the addressed byte or halfword and extend it per req_unsigned.
- Word loads SHALL ignore req_unsigned.
REQ-013 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-014 Memory contents SHALL be zero at time 0 and SHALL NOT be altered by reset.

Reset
REQ-015 While RST=0 the block SHALL force state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and err_count=0, without waiting for a CLK edge.
REQ-016 req_ready SHALL be 1 in the first cycle after RST deasserts.
REQ-017 RST assertion during WAIT or RESP SHALL drop the in-flight response, with no rsp_valid pulse.
REQ-018 A store whose accept edge preceded RST assertion SHALL remain in memory.

Verification
REQ-019 Word round trip, RD_LAT=1:
- store word 0xDEADBEEF @0x08 -> rsp_valid one cycle later, err=0.
- load word @0x08 -> rsp_rdata=0xDEADBEEF, one cycle after accept.
REQ-020 Byte and half extension, after the store in REQ-019:
- load byte signed @0x09 -> 0xFFFFFFBE.
- load byte unsigned @0x09 -> 0x000000BE.
- load half signed @0x0A -> 0xFFFFDEAD.
- store byte 0x11 @0x0B, then load word @0x08 -> 0x11ADBEEF.
REQ-021 Faults, DEPTH=64:
- load word @0x06, load half @0x03, size=11, store word @0x100 -> each gives rsp_err=1 and rsp_rdata=0.
- err_count=4 afterwards; word @0x100 unchanged.
- 300 faults -> err_count=255.
REQ-022 Latency, RD_LAT=3:
- load accepted at edge N -> rsp_valid at edge N+3, req_ready low from N to N+3, high at N+4.
- back-to-back stores complete every 2 cycles.
REQ-023 Reset mid-load, RD_LAT=3:
- assert RST one cycle after accept -> outputs 0 immediately, no rsp_valid.
- after release, req_ready=1 and the word stored earlier reads back intact.
